// File: rtl/pc_unit.sv
// Fetch-stage program counter with buffered stalled-branch redirect.
// Optional fetch-address check enabled by defining PC_ADDR_CHECK_EN.
module pc_unit #(
  parameter int unsigned      WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VEC   = 32'h0000_3000,
  parameter logic [WIDTH-1:0] HANDLER_VEC = 32'h0000_4180,
  parameter logic [WIDTH-1:0] TEXT_LO     = 32'h0000_3000,
  parameter logic [WIDTH-1:0] TEXT_HI     = 32'h0000_4ffc
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             IntReq,
  input  logic             eret,
  input  logic [WIDTH-1:0] epc,
  input  logic             br_valid,
  input  logic [WIDTH-1:0] br_target,
  output logic [WIDTH-1:0] PC,
  output logic             pend_valid,
  output logic [4:0]       exccode_PC
);

  typedef enum logic {
    RUN  = 1'b0,
    PEND = 1'b1
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pend_target_q;

  // Exception and ERET override everything, including a stalled branch
  // arriving on the same edge, so any buffered target is dropped there.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_VEC;
      state_q       <= RUN;
      pend_target_q <= '0;
    end else if (IntReq) begin
      pc_q    <= HANDLER_VEC;
      state_q <= RUN;
    end else if (eret) begin
      pc_q    <= epc;
      state_q <= RUN;
    end else if (en) begin
      state_q <= RUN;
      if (br_valid)
        pc_q <= br_target;
      else if (state_q == PEND)
        pc_q <= pend_target_q;
      else
        pc_q <= pc_q + WIDTH'(4);
    end else if (br_valid) begin
      pend_target_q <= br_target;
      state_q       <= PEND;
    end
  end

  assign PC         = pc_q;
  assign pend_valid = (state_q == PEND);

`ifdef PC_ADDR_CHECK_EN
  assign exccode_PC = ((pc_q[1:0] != 2'b00) || (pc_q < TEXT_LO) || (pc_q > TEXT_HI))
                      ? 5'd4 : 5'd0;
`else
  logic unused_text_window;
  assign unused_text_window = ^{TEXT_LO, TEXT_HI};
  assign exccode_PC         = '0;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Directed scoreboard bench for pc_unit; expectations follow PC_ADDR_CHECK_EN.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        reset, en, IntReq, eret, br_valid;
  logic [31:0] epc, br_target;
  logic [31:0] PC;
  logic        pend_valid;
  logic [4:0]  exccode_PC;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  typedef struct {
    logic [31:0] pc;
    logic        pend;
    logic [4:0]  exc;
    string       tag;
  } exp_t;

  exp_t sb[$];

  pc_unit #(
    .WIDTH       (32),
    .RESET_VEC   (32'h0000_3000),
    .HANDLER_VEC (32'h0000_4180),
    .TEXT_LO     (32'h0000_3000),
    .TEXT_HI     (32'h0000_4ffc)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .IntReq     (IntReq),
    .eret       (eret),
    .epc        (epc),
    .br_valid   (br_valid),
    .br_target  (br_target),
    .PC         (PC),
    .pend_valid (pend_valid),
    .exccode_PC (exccode_PC)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] exp_exc(input logic [31:0] pc);
`ifdef PC_ADDR_CHECK_EN
    if (pc[1:0] != 2'b00 || pc < 32'h0000_3000 || pc > 32'h0000_4ffc) return 5'd4;
    return 5'd0;
`else
    return 5'd0;
`endif
  endfunction

  task automatic step(input logic r, input logic e, input logic irq, input logic er,
                      input logic [31:0] ep, input logic bv, input logic [31:0] bt,
                      input logic [31:0] xpc, input logic xpend, input string tag);
    exp_t x;
    reset = r; en = e; IntReq = irq; eret = er; epc = ep; br_valid = bv; br_target = bt;
    x.pc = xpc; x.pend = xpend; x.exc = exp_exc(xpc); x.tag = tag;
    sb.push_back(x);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    n_cmp++;
    assert (PC === x.pc) else begin
      n_bad++;
      $error("FAIL %s.PC observed=%h expected=%h", x.tag, PC, x.pc);
    end
    n_cmp++;
    assert (pend_valid === x.pend) else begin
      n_bad++;
      $error("FAIL %s.pend observed=%b expected=%b", x.tag, pend_valid, x.pend);
    end
    n_cmp++;
    assert (exccode_PC === x.exc) else begin
      n_bad++;
      $error("FAIL %s.exc observed=%0d expected=%0d", x.tag, exccode_PC, x.exc);
    end
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; IntReq = 1'b0; eret = 1'b0; br_valid = 1'b0;
    epc = '0; br_target = '0;
    //   rst en  irq eret epc           bv   target        exp PC        pend
    step(1, 0, 0, 0, 32'h0,        0, 32'h0,        32'h0000_3000, 0, "reset");
    step(0, 1, 0, 0, 32'h0,        0, 32'h0,        32'h0000_3004, 0, "inc1");
    step(0, 1, 0, 0, 32'h0,        0, 32'h0,        32'h0000_3008, 0, "inc2");
    step(0, 1, 0, 0, 32'h0,        0, 32'h0,        32'h0000_300C, 0, "inc3");
    step(0, 1, 0, 0, 32'h0,        0, 32'h0,        32'h0000_3010, 0, "inc4");
    // stalled branch buffered, then applied when en rises
    step(0, 0, 0, 0, 32'h0,        1, 32'h0000_3200, 32'h0000_3010, 1, "stall_br");
    step(0, 0, 0, 0, 32'h0,        0, 32'h0,        32'h0000_3010, 1, "stall_hold1");
    step(0, 0, 0, 0, 32'h0,        0, 32'h0,        32'h0000_3010, 1, "stall_hold2");
    step(0, 1, 0, 0, 32'h0,        0, 32'h0,        32'h0000_3200, 0, "pend_apply");
    // IntReq discards the buffered target
    step(0, 0, 0, 0, 32'h0,        1, 32'h0000_3300, 32'h0000_3200, 1, "stall_br2");
    step(0, 0, 1, 0, 32'h0,        0, 32'h0,        32'h0000_4180, 0, "intreq");
    step(0, 1, 0, 0, 32'h0,        0, 32'h0,        32'h0000_4184, 0, "after_int");
    // eret beats branch
    step(0, 1, 0, 1, 32'h0000_3044, 1, 32'h0000_3300, 32'h0000_3044, 0, "eret_vs_br");
    // illegal targets loaded and flagged
    step(0, 1, 0, 0, 32'h0,        1, 32'h0000_3002, 32'h0000_3002, 0, "misalign");
    step(0, 1, 0, 0, 32'h0,        1, 32'h0000_5000, 32'h0000_5000, 0, "above_hi");
    step(0, 1, 0, 0, 32'h0,        1, 32'h0000_4ffc, 32'h0000_4ffc, 0, "at_hi");
    step(0, 1, 0, 0, 32'h0,        0, 32'h0,        32'h0000_5000, 0, "inc_past_hi");
    step(0, 1, 0, 0, 32'h0,        1, 32'h0000_2ffc, 32'h0000_2ffc, 0, "below_lo");
    step(0, 1, 0, 0, 32'h0,        0, 32'h0,        32'h0000_3000, 0, "at_lo");
    step(0, 1, 0, 0, 32'h0,        1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0, "top");
    step(0, 1, 0, 0, 32'h0,        0, 32'h0,        32'h0000_0000, 0, "wrap");
    // later stalled branch overwrites buffered target
    step(0, 0, 0, 0, 32'h0,        1, 32'h0000_3100, 32'h0000_0000, 1, "pend_a");
    step(0, 0, 0, 0, 32'h0,        1, 32'h0000_3120, 32'h0000_0000, 1, "pend_b");
    step(0, 1, 0, 0, 32'h0,        0, 32'h0,        32'h0000_3120, 0, "pend_b_apply");
    // IntReq outranks eret; eret on a stalled-branch edge leaves RUN
    step(0, 1, 1, 1, 32'h0000_3050, 1, 32'h0000_3400, 32'h0000_4180, 0, "int_vs_eret");
    step(0, 0, 0, 1, 32'h0000_3050, 1, 32'h0000_3400, 32'h0000_3050, 0, "eret_stall_br");
    step(0, 0, 0, 0, 32'h0,        0, 32'h0,        32'h0000_3050, 0, "stall_idle");
    // fresh branch supersedes buffered one
    step(0, 0, 0, 0, 32'h0,        1, 32'h0000_3500, 32'h0000_3050, 1, "pend_c");
    step(0, 1, 0, 0, 32'h0,        1, 32'h0000_3600, 32'h0000_3600, 0, "fresh_br");
    step(0, 1, 0, 0, 32'h0,        0, 32'h0,        32'h0000_3604, 0, "no_stale");
    // reset clears a pending redirect
    step(0, 0, 0, 0, 32'h0,        1, 32'h0000_3700, 32'h0000_3604, 1, "pend_d");
    step(1, 0, 0, 0, 32'h0,        0, 32'h0,        32'h0000_3000, 0, "reset_pend");
    step(0, 1, 0, 0, 32'h0,        0, 32'h0,        32'h0000_3004, 0, "post_reset");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
